// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
//
// Each cycle, at most one execution unit with a dispatchable entry is granted
// (req_ready, combinational). The granted unit registers its result at the
// closing edge, and this block broadcasts that result on the CDB during the
// following cycle. The tag and data go through a mux selected by the recorded
// grant index.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   flush        pipeline flush; cancels grants and suppresses broadcast
//   req_valid    per-unit request
//   req_ready    per-unit grant, one-hot or zero
//   result_tag   per-unit registered ROB tag, unit k at [k*ROB_WIDTH +: ROB_WIDTH]
//   result_data  per-unit registered result, unit k at [k*32 +: 32]
//   cdb_valid    broadcast valid
//   cdb_tag      broadcast ROB tag (zero when not valid)
//   cdb_data     broadcast data (zero when not valid)
module cdb_arbiter #(
    parameter int unsigned N_UNIT    = 4,
    parameter int unsigned ROB_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [N_UNIT-1:0]             req_valid,
    output logic [N_UNIT-1:0]             req_ready,
    input  logic [N_UNIT*ROB_WIDTH-1:0]   result_tag,
    input  logic [N_UNIT*32-1:0]          result_data,
    output logic                          cdb_valid,
    output logic [ROB_WIDTH-1:0]          cdb_tag,
    output logic [31:0]                   cdb_data
);

    localparam int unsigned PTR_W = (N_UNIT > 4) ? 3 : 2;
    localparam logic [PTR_W:0] NUnitW = (PTR_W + 1)'(N_UNIT);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [PTR_W-1:0]  gnt_idx_q, gnt_idx_d;

    logic [N_UNIT-1:0] req_rot;
    logic [PTR_W:0]    offset;
    logic [PTR_W:0]    sel_sum;
    logic [PTR_W:0]    nxt_sum;
    logic [PTR_W-1:0]  gnt_sel;
    logic              gnt_found;

    // Arbitration: rotate requests so the pointer's unit sits at bit 0.
    // The lowest set bit is then the first requester at or after ptr.
    always_comb begin
        req_rot = N_UNIT'({req_valid, req_valid} >> ptr_q);
        offset  = '0;
        for (int j = N_UNIT - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = (PTR_W + 1)'(j);
            end
        end
        sel_sum = {1'b0, ptr_q} + offset;
        if (sel_sum >= NUnitW) begin
            sel_sum = sel_sum - NUnitW;
        end
        gnt_sel   = PTR_W'(sel_sum);
        gnt_found = (|req_valid) && !flush && !reset;
        req_ready = gnt_found ? (N_UNIT'(1) << gnt_sel) : '0;
    end

    // Next state: ptr moves past the granted unit and holds otherwise.
    // This includes flush cycles, which can never grant.
    always_comb begin
        nxt_sum = {1'b0, gnt_sel} + (PTR_W + 1)'(1);
        if (nxt_sum == NUnitW) begin
            nxt_sum = '0;
        end
        ptr_d       = gnt_found ? PTR_W'(nxt_sum) : ptr_q;
        gnt_valid_d = gnt_found;
        gnt_idx_d   = gnt_found ? gnt_sel : gnt_idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
        end
    end

    // Broadcast the result of last cycle's grant. The valid path has no added
    // latency, so a flush in this cycle kills the broadcast immediately.
    always_comb begin
        cdb_valid = gnt_valid_q && !flush;
        cdb_tag   = '0;
        cdb_data  = '0;
        for (int k = 0; k < N_UNIT; k++) begin
            if (cdb_valid && (gnt_idx_q == PTR_W'(k))) begin
                cdb_tag  = result_tag[k*ROB_WIDTH +: ROB_WIDTH];
                cdb_data = result_data[k*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus for cdb_arbiter.
// The bench model holds the round-robin pointer and the last grant as plain
// integers. It is checked against the DUT at every falling edge.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = 5;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*RW-1:0]   result_tag;
    logic [N*32-1:0]   result_data;
    logic              cdb_valid;
    logic [RW-1:0]     cdb_tag;
    logic [31:0]       cdb_data;

    int n_run;
    int n_fail;

    // Model state: what the DUT holds during the current cycle.
    int m_ptr;
    int m_gidx;
    bit m_gv;
    bit rst_pulse;
    int wait_cnt[N];
    int exp_g[8];

    cdb_arbiter #(
        .N_UNIT    (N),
        .ROB_WIDTH (RW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .result_tag  (result_tag),
        .result_data (result_data),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_res(input int k, input logic [31:0] tag, input logic [31:0] data);
        result_tag[k*RW +: RW]  = tag[RW-1:0];
        result_data[k*32 +: 32] = data;
    endtask

    // Per-cycle compare and model update, called on the falling edge.
    task automatic model_step();
        int            grant;
        int            worst;
        logic [N-1:0]  e_ready;
        logic          e_cv;
        logic [RW-1:0] e_tag;
        logic [31:0]   e_data;
        if (rst_pulse || reset) begin
            m_ptr     = 0;
            m_gv      = 1'b0;
            m_gidx    = 0;
            rst_pulse = 1'b0;
        end
        grant = -1;
        if (!reset && !flush) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (grant < 0 && req_valid[k]) grant = k;
            end
        end
        e_ready = '0;
        if (grant >= 0) e_ready[grant] = 1'b1;
        e_cv   = m_gv && !flush && !reset;
        e_tag  = e_cv ? result_tag[m_gidx*RW +: RW] : '0;
        e_data = e_cv ? result_data[m_gidx*32 +: 32] : '0;
        chk("req_ready", req_ready, e_ready);
        chk("cdb_valid", cdb_valid, e_cv);
        chk("cdb_tag", cdb_tag, e_tag);
        chk("cdb_data", cdb_data, e_data);
        worst = 0;
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && !flush && !reset && grant != k) wait_cnt[k]++;
            else wait_cnt[k] = 0;
            if (wait_cnt[k] > worst) worst = wait_cnt[k];
        end
        if (worst > 0) chk("wait_bound", (worst > N - 1), 0);
        if (grant >= 0) begin
            m_ptr  = (grant + 1) % N;
            m_gv   = 1'b1;
            m_gidx = grant;
        end else begin
            m_gv = 1'b0;
        end
    endtask

    task automatic tick(input logic [N-1:0] rv, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        req_valid = rv;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        model_step();
    endtask

    initial begin
        n_run       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        req_valid   = '0;
        result_tag  = '0;
        result_data = '0;
        m_ptr       = 0;
        m_gidx      = 0;
        m_gv        = 1'b0;
        rst_pulse   = 1'b0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state, with requests present to show they are gated.
        tick(4'b1111, 1'b0, 1'b1);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_tag", cdb_tag, 5'd0);
        tick(4'b0000, 1'b0, 1'b0);

        // Single grant to unit 2, broadcast one cycle later.
        tick(4'b0100, 1'b0, 1'b0);
        chk("single_ready", req_ready, 4'b0100);
        set_res(2, 32'd5, 32'h1234_5678);
        tick(4'b0000, 1'b0, 1'b0);
        chk("single_cdb_valid", cdb_valid, 1'b1);
        chk("single_cdb_tag", cdb_tag, 5'd5);
        chk("single_cdb_data", cdb_data, 32'h1234_5678);
        chk("single_ready_idle", req_ready, 4'b0000);
        tick(4'b0000, 1'b0, 1'b0);
        chk("single_cdb_done", cdb_valid, 1'b0);
        chk("single_data_zero", cdb_data, 32'h0);

        // Back to ptr=0, then all units requesting for 8 cycles.
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) set_res(k, 32'(10 + k), 32'hA000 + 32'(k));
        for (int i = 0; i < 8; i++) begin
            tick(4'b1111, 1'b0, 1'b0);
            chk("rr_ready", req_ready, 4'b0001 << exp_g[i]);
            if (i > 0) chk("rr_cdb_tag", cdb_tag, 5'(10 + exp_g[i-1]));
        end

        // Wrap: grant unit 2 (ptr=3), then units 3 and 0 from 4'b1001.
        tick(4'b0100, 1'b0, 1'b0);
        chk("wrap_pre", req_ready, 4'b0100);
        tick(4'b1001, 1'b0, 1'b0);
        chk("wrap_u3", req_ready, 4'b1000);
        tick(4'b1001, 1'b0, 1'b0);
        chk("wrap_u0", req_ready, 4'b0001);

        // Flush right after granting unit 1: no broadcast, no grant, ptr held at 2.
        tick(4'b0010, 1'b0, 1'b0);
        chk("flush_pre", req_ready, 4'b0010);
        tick(4'b1111, 1'b1, 1'b0);
        chk("flush_ready", req_ready, 4'b0000);
        chk("flush_cdb_valid", cdb_valid, 1'b0);
        tick(4'b1111, 1'b0, 1'b0);
        chk("flush_ptr_held", req_ready, 4'b0100);

        // Grant unit 0, then pulse reset in the middle of the broadcast cycle.
        tick(4'b0001, 1'b0, 1'b0);
        chk("arst_pre_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = 4'b1100;
        #1;
        chk("arst_before", cdb_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_cdb_valid", cdb_valid, 1'b0);
        chk("arst_cdb_tag", cdb_tag, 5'd0);
        chk("arst_ready", req_ready, 4'b0000);
        reset     = 1'b0;
        rst_pulse = 1'b1;
        #1;
        chk("arst_ptr0", req_ready, 4'b0100);
        @(negedge clk);
        model_step();

        // Random traffic with occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) set_res(k, $urandom, $urandom);
            tick(4'($urandom), ($urandom_range(15) == 0), 1'b0);
        end
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
